// File: rtl/uart_msg_tx_pkg.sv
// uart_msg_tx_pkg: shared FSM states, default timing constants and the message ROM contents.
package uart_msg_tx_pkg;
    typedef enum logic [2:0] {IDLE, START_BIT, DATA, STOP, FINISH} state_e;
    localparam int DEF_CLK_DIV = 5208;
    localparam int DEF_MSG_LEN = 13;
    localparam logic [7:0] MSG [13] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57,
                                        8'h4F, 8'h52, 8'h4C, 8'h44, 8'h0D, 8'h0A};
    function automatic logic [7:0] msg_byte(input int i);
        return (i >= 0 && i < 13) ? MSG[i] : 8'h00;
    endfunction
endpackage

// File: rtl/uart_msg_tx_if.sv
// uart_msg_tx_if: request handshake and serial/status outputs of the message transmitter.
interface uart_msg_tx_if;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       tx;
    logic       busy;
    logic       done;
    modport master (output start, byte_valid, byte_data, input byte_ready, tx, busy, done);
    modport slave  (input start, byte_valid, byte_data, output byte_ready, tx, busy, done);
endinterface

// File: rtl/uart_msg_tx_rom.sv
// uart_msg_tx_rom: combinational message lookup, zero beyond the last entry.
module uart_msg_tx_rom
    import uart_msg_tx_pkg::*;
#(
    parameter int MSG_LEN = DEF_MSG_LEN,
    parameter int IW      = 4
) (
    input  logic [IW-1:0] addr_i,
    output logic [7:0]    data_o
);
    assign data_o = (int'(addr_i) < MSG_LEN) ? msg_byte(int'(addr_i)) : 8'h00;
endmodule

// File: rtl/uart_msg_tx.sv
// uart_msg_tx: 8N1 LSB-first UART transmitter sending either the ROM message or single bytes.
// Outputs are registered from the current state, so TX trails the FSM by one cycle.
module uart_msg_tx
    import uart_msg_tx_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int MSG_LEN = DEF_MSG_LEN
) (
    input logic          clk_i,
    input logic          rst_i,
    uart_msg_tx_if.slave bus
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int IW = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1;
    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    bit_q, bit_d;
    logic [IW-1:0] idx_q, idx_d, rom_addr;
    logic [7:0]    shift_q, shift_d, rom_data;
    logic          msg_q, msg_d, tx_q, busy_q, done_q, bit_end, last;
    assign bit_end        = tmr_q == TW'(CLK_DIV - 1);
    assign last           = !msg_q || idx_q == IW'(MSG_LEN - 1);
    // ROM is pre-addressed with the next byte so a new frame can start without a gap
    assign rom_addr       = state_q == IDLE ? '0 : idx_q + IW'(1);
    assign bus.byte_ready = state_q == IDLE && !bus.start && !rst_i;
    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    uart_msg_tx_rom #(.MSG_LEN(MSG_LEN), .IW(IW)) u_rom (.addr_i(rom_addr), .data_o(rom_data));
    always_comb begin
        state_d = state_q;
        tmr_d   = (state_q == IDLE || state_q == FINISH || bit_end) ? '0 : tmr_q + TW'(1);
        bit_d   = bit_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        msg_d   = msg_q;
        unique case (state_q)
            IDLE: begin
                bit_d = '0;
                if (bus.start) begin
                    msg_d   = 1'b1;
                    idx_d   = '0;
                    shift_d = rom_data;
                    state_d = START_BIT;
                end else if (bus.byte_valid) begin
                    msg_d   = 1'b0;
                    shift_d = bus.byte_data;
                    state_d = START_BIT;
                end
            end
            START_BIT: state_d = bit_end ? DATA : START_BIT;
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (bit_end) begin
                if (last) state_d = FINISH;
                else begin
                    idx_d   = idx_q + IW'(1);
                    shift_d = rom_data;
                    state_d = START_BIT;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            msg_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            msg_q   <= msg_d;
            tx_q    <= state_q == START_BIT ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
            busy_q  <= state_q != IDLE;
            done_q  <= state_q == FINISH;
        end
    end
endmodule

// File: tb/tb_uart_msg_tx.sv
// tb_uart_msg_tx: directed vectors and corner-case sequences for uart_msg_tx at CLK_DIV=4.
module tb_uart_msg_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    uart_msg_tx_if bus();
    uart_msg_tx #(.CLK_DIV(4), .MSG_LEN(13)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    vec_t       vecs [4];
    logic [7:0] msg [13] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57,
                             8'h4F, 8'h52, 8'h4C, 8'h44, 8'h0D, 8'h0A};
    logic       tx_log [1:521];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // frame bit i is the i-th bit on the line (bit 0 = start bit); call right after the accepting edge
    task automatic wait_frame(input logic [9:0] exp, input string nm);
        logic [9:0] got = '0;
        bit done_ok = 1'b1;
        bit busy_ok = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            step();
            if ((c - 1) % 4 == 2) got[(c - 1) / 4] = bus.tx;
            if (bus.done !== (c == 41)) done_ok = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        check({nm, "_frame"}, got, exp);
        check({nm, "_done_at_41"}, done_ok, 1);
        check({nm, "_busy"}, busy_ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int ndone, done_c, nquiet;
        bit ready_ok, framing_ok, busy_ok;
        logic [7:0] b;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h3C, 10'b1001111000};
        vecs[2] = '{8'h81, 10'b1100000010};
        vecs[3] = '{8'h55, 10'b1010101010};
        repeat (3) step();
        check("rst_tx", bus.tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ready", bus.byte_ready, 0);
        rst = 1'b0;
        repeat (2) step();
        check("idle_ready", bus.byte_ready, 1);
        for (int i = 0; i < 4; i++) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = vecs[i].data;
            #1;
            check($sformatf("vec%0d_ready", i), bus.byte_ready, 1);
            step();
            bus.byte_valid = 1'b0;
            bus.byte_data  = ~vecs[i].data;
            wait_frame(vecs[i].frame, $sformatf("vec%0d", i));
            step();
            check($sformatf("vec%0d_idle_busy", i), bus.busy, 0);
            check($sformatf("vec%0d_idle_tx", i), bus.tx, 1);
        end
        // message with a simultaneous byte request; extra requests while busy must be ignored
        bus.start      = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        #1;
        check("msg_ready_low_with_start", bus.byte_ready, 0);
        step();
        bus.start = 1'b0;
        ndone = 0; done_c = 0; ready_ok = 1'b1; busy_ok = 1'b1;
        for (int c = 1; c <= 521; c++) begin
            step();
            tx_log[c] = bus.tx;
            if (bus.done === 1'b1) begin
                ndone++;
                done_c = c;
            end
            if (c <= 520 && bus.byte_ready !== 1'b0) ready_ok = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (c == 100) bus.byte_valid = 1'b0;
            bus.start = (c == 200);
        end
        bus.start = 1'b0;
        framing_ok = 1'b1;
        for (int f = 0; f < 13; f++) begin
            for (int k = 1; k <= 8; k++) b[k - 1] = tx_log[40 * f + 4 * k + 3];
            if (tx_log[40 * f + 3] !== 1'b0 || tx_log[40 * f + 39] !== 1'b1) framing_ok = 1'b0;
            check($sformatf("msg_byte%0d", f), b, msg[f]);
        end
        check("msg_framing", framing_ok, 1);
        check("msg_done_count", ndone, 1);
        check("msg_done_cycle", done_c, 521);
        check("msg_ready_low", ready_ok, 1);
        check("msg_busy", busy_ok, 1);
        nquiet = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.tx === 1'b1 && bus.busy === 1'b0) nquiet++;
        end
        check("msg_no_dropped_byte_sent", nquiet, 12);
        // reset in the middle of an all-zero frame
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h00;
        step();
        bus.byte_valid = 1'b0;
        repeat (15) step();
        check("pre_rst_tx", bus.tx, 0);
        rst = 1'b1;
        step();
        check("mid_rst_tx", bus.tx, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (bus.done !== 1'b0 || bus.tx !== 1'b1) ndone++;
        end
        check("post_rst_quiet", ndone, 0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h55;
        #1;
        check("post_rst_ready", bus.byte_ready, 1);
        step();
        bus.byte_valid = 1'b0;
        wait_frame(10'b1010101010, "post_rst_55");
        // back-to-back bytes with VALID held across the DONE cycle
        step();
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h00;
        step();
        bus.byte_data = 8'hFF;
        wait_frame(10'b1000000000, "b2b_00");
        check("b2b_ready_at_done", bus.byte_ready, 1);
        step();
        bus.byte_valid = 1'b0;
        wait_frame(10'b1111111110, "b2b_ff");
        step();
        check("b2b_idle_busy", bus.busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
